write_once_reg_bank: RTL and testbench



---
 rtl/write_once_pkg.sv | 12 +
 rtl/write_once_unlock_fsm.sv | 71 +++++++
 rtl/write_once_reg_bank.sv | 99 +++++++++
 tb/tb_write_once_reg_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/write_once_pkg.sv
// Shared types and default unlock keys for the write-once configuration bank.
package write_once_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } unlock_state_e;

    localparam logic [15:0] DEF_KEY1 = 16'hA5A5;
    localparam logic [15:0] DEF_KEY2 = 16'h5A5A;

endpackage

// File: rtl/write_once_unlock_fsm.sv
// Two-key unlock sequencer: KEY1 arms, KEY2 within the timeout window fires a
// single-cycle unlock strobe that the bank consumes at the same clock edge.
module write_once_unlock_fsm
    import write_once_pkg::*;
#(
    parameter int               WIDTH          = 16,
    parameter logic [WIDTH-1:0] KEY1           = WIDTH'(DEF_KEY1),
    parameter logic [WIDTH-1:0] KEY2           = WIDTH'(DEF_KEY2),
    parameter int               UNLOCK_TIMEOUT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_valid_i,
    input  logic [WIDTH-1:0] key_i,
    output logic             unlock_o
);

    localparam int TMR_W = (UNLOCK_TIMEOUT > 2) ? $clog2(UNLOCK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UNLOCK_TIMEOUT - 1);

    unlock_state_e    state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             unlock_s;

    // State and timer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state; a key strobe in ARMED is decided before the timeout so KEY2 on the last cycle wins.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        unlock_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_valid_i && (key_i == KEY1)) begin
                    state_d = ST_ARMED;
                    timer_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (key_valid_i) begin
                    unlock_s = (key_i == KEY2);
                    state_d  = ST_IDLE;
                    timer_d  = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign unlock_o = unlock_s;

endmodule

// File: rtl/write_once_reg_bank.sv
// Tamper-resistant configuration store: each register takes one write after
// reset or unlock; rejected writes are flagged and counted (saturating).
module write_once_reg_bank
    import write_once_pkg::*;
#(
    parameter int               WIDTH          = 16,
    parameter int               NUM_REGS       = 4,
    parameter int               ADDR_W         = 2,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter logic [WIDTH-1:0] KEY1           = WIDTH'(DEF_KEY1),
    parameter logic [WIDTH-1:0] KEY2           = WIDTH'(DEF_KEY2),
    parameter int               UNLOCK_TIMEOUT = 8,
    parameter int               ERR_CNT_W      = 8
) (
    input  logic                      Clk,
    input  logic                      ip_reset,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      key_valid,
    input  logic [WIDTH-1:0]          key,
    output logic [NUM_REGS*WIDTH-1:0] Data_out,
    output logic [NUM_REGS-1:0]       lock_status,
    output logic                      wr_err,
    output logic [ERR_CNT_W-1:0]      err_count,
    output logic                      unlock_done
);

    logic [NUM_REGS-1:0][WIDTH-1:0] data_q, data_d;
    logic [NUM_REGS-1:0]            lock_q, lock_d;
    logic [NUM_REGS-1:0]            lock_clr_s;
    logic [NUM_REGS-1:0]            hit_s;
    logic [ERR_CNT_W-1:0]           err_q, err_d;
    logic                           wr_err_q;
    logic                           unlock_done_q;
    logic                           unlock_s;
    logic                           accept_s;
    logic                           reject_s;

    write_once_unlock_fsm #(
        .WIDTH          (WIDTH),
        .KEY1           (KEY1),
        .KEY2           (KEY2),
        .UNLOCK_TIMEOUT (UNLOCK_TIMEOUT)
    ) u_unlock_fsm (
        .clk_i       (Clk),
        .rst_i       (ip_reset),
        .key_valid_i (key_valid),
        .key_i       (key),
        .unlock_o    (unlock_s)
    );

    // Unlock clears the locks first so a same-cycle write is judged against the cleared state.
    always_comb begin
        lock_clr_s = unlock_s ? '0 : lock_q;
        hit_s      = '0;
        data_d     = data_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit_s[i] = write && (addr == ADDR_W'(i));
            if (hit_s[i] && !lock_clr_s[i]) begin
                data_d[i] = wdata;
            end else begin
                data_d[i] = data_q[i];
            end
        end
        accept_s = |(hit_s & ~lock_clr_s);
        reject_s = write && !accept_s;
        lock_d   = lock_clr_s | hit_s;
        if (reject_s && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // Bank state and registered status outputs.
    always_ff @(posedge Clk) begin
        if (ip_reset) begin
            data_q        <= {NUM_REGS{RESET_VAL}};
            lock_q        <= '0;
            err_q         <= '0;
            wr_err_q      <= 1'b0;
            unlock_done_q <= 1'b0;
        end else begin
            data_q        <= data_d;
            lock_q        <= lock_d;
            err_q         <= err_d;
            wr_err_q      <= reject_s;
            unlock_done_q <= unlock_s;
        end
    end

    assign Data_out    = data_q;
    assign lock_status = lock_q;
    assign wr_err      = wr_err_q;
    assign err_count   = err_q;
    assign unlock_done = unlock_done_q;

endmodule

// File: tb/tb_write_once_reg_bank.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a deadline-based behavioural model of the bank.
module tb_write_once_reg_bank;

    localparam int          W   = 16;
    localparam int          N   = 4;
    localparam int          AW  = 2;
    localparam int          TO  = 8;
    localparam int          EW  = 8;
    localparam logic [15:0] K1  = 16'hA5A5;
    localparam logic [15:0] K2  = 16'h5A5A;

    logic          Clk = 1'b0;
    logic          ip_reset, write, key_valid;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata, key;
    logic [N*W-1:0] Data_out;
    logic [N-1:0]  lock_status;
    logic          wr_err, unlock_done;
    logic [EW-1:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [W-1:0] m_data [N];
    logic         m_lock [N];
    int           m_err;
    bit           m_armed;
    int           m_t1;
    int           m_cyc;
    bit           m_wr_err, m_unlock;

    write_once_reg_bank dut (
        .Clk(Clk), .ip_reset(ip_reset), .write(write), .addr(addr), .wdata(wdata),
        .key_valid(key_valid), .key(key), .Data_out(Data_out), .lock_status(lock_status),
        .wr_err(wr_err), .err_count(err_count), .unlock_done(unlock_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // KEY2 is honoured up to TO edges after the KEY1 edge; any other key or an expired deadline disarms.
    task automatic model_step();
        bit unl;
        m_wr_err = 1'b0;
        m_unlock = 1'b0;
        if (ip_reset) begin
            for (int i = 0; i < N; i++) begin m_data[i] = '0; m_lock[i] = 1'b0; end
            m_err = 0;
            m_armed = 1'b0;
        end else begin
            unl = 1'b0;
            if (m_armed) begin
                if (key_valid) begin
                    unl = (key == K2);
                    m_armed = 1'b0;
                end else if (m_cyc - m_t1 >= TO) begin
                    m_armed = 1'b0;
                end
            end else if (key_valid && key == K1) begin
                m_armed = 1'b1;
                m_t1 = m_cyc;
            end
            if (unl) begin
                for (int i = 0; i < N; i++) m_lock[i] = 1'b0;
                m_unlock = 1'b1;
            end
            if (write) begin
                if (int'(addr) < N && !m_lock[addr]) begin
                    m_data[addr] = wdata;
                    m_lock[addr] = 1'b1;
                end else begin
                    m_wr_err = 1'b1;
                    if (m_err < (1 << EW) - 1) m_err++;
                end
            end
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("data[%0d]", i), 64'(Data_out[i*W +: W]), 64'(m_data[i]));
            chk($sformatf("lock[%0d]", i), 64'(lock_status[i]), 64'(m_lock[i]));
        end
        chk("wr_err", 64'(wr_err), 64'(m_wr_err));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("unlock_done", 64'(unlock_done), 64'(m_unlock));
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        write = 1'b0; key_valid = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [W-1:0] d);
        write = 1'b1; addr = AW'(a); wdata = d; key_valid = 1'b0;
        cycle();
        idle();
    endtask

    task automatic do_key(input logic [W-1:0] k);
        key_valid = 1'b1; key = k; write = 1'b0;
        cycle();
        idle();
    endtask

    initial begin
        int r;
        ip_reset = 1'b1; write = 1'b0; key_valid = 1'b0; addr = '0; wdata = '0; key = '0;
        m_cyc = 0; m_t1 = 0; m_armed = 1'b0; m_err = 0;
        for (int i = 0; i < N; i++) begin m_data[i] = 16'hDEAD; m_lock[i] = 1'b1; end
        cycle(); cycle();
        chk("reset Data_out", 64'(Data_out), 64'h0);
        chk("reset lock", 64'(lock_status), 64'h0);
        chk("reset err_count", 64'(err_count), 64'h0);
        ip_reset = 1'b0;
        cycle();

        do_write(1, 16'h1234);
        chk("wr1 data", 64'(Data_out[31:16]), 64'h1234);
        chk("wr1 lock", 64'(lock_status), 64'h2);
        chk("wr1 wr_err", 64'(wr_err), 64'h0);
        do_write(1, 16'hFFFF);
        chk("rewrite data", 64'(Data_out[31:16]), 64'h1234);
        chk("rewrite wr_err", 64'(wr_err), 64'h1);
        chk("rewrite err_count", 64'(err_count), 64'h1);
        cycle();
        chk("wr_err single pulse", 64'(wr_err), 64'h0);
        for (int i = 0; i < 300; i++) begin do_write(1, 16'hFFFF); cycle(); end
        chk("err saturate", 64'(err_count), 64'hFF);

        do_write(0, 16'h1111); do_write(2, 16'h2222); do_write(3, 16'h3333);
        chk("all locked", 64'(lock_status), 64'hF);
        do_key(K1); cycle(); cycle(); do_key(K2);
        chk("unlock pulse", 64'(unlock_done), 64'h1);
        chk("unlock lock", 64'(lock_status), 64'h0);
        chk("unlock data", 64'(Data_out), 64'h3333_2222_1234_1111);
        do_write(2, 16'hABCD);
        chk("post-unlock write", 64'(lock_status), 64'h4);

        do_key(K1); for (int i = 0; i < 8; i++) cycle(); do_key(K2);
        chk("timeout no unlock", 64'(lock_status), 64'h4);
        chk("timeout no pulse", 64'(unlock_done), 64'h0);
        do_key(K1); do_key(16'h1111); do_key(K2);
        chk("wrong key", 64'(lock_status), 64'h4);
        do_key(K1); for (int i = 0; i < 7; i++) cycle(); do_key(K2);
        chk("last-cycle KEY2", 64'(unlock_done), 64'h1);

        for (int i = 0; i < N; i++) do_write(i, 16'(16'h0100 * i));
        do_key(K1); cycle();
        key_valid = 1'b1; key = K2; write = 1'b1; addr = 2'd0; wdata = 16'hBEEF;
        cycle(); idle();
        chk("simul data0", 64'(Data_out[15:0]), 64'hBEEF);
        chk("simul lock", 64'(lock_status), 64'h1);
        chk("simul unlock", 64'(unlock_done), 64'h1);
        chk("simul wr_err", 64'(wr_err), 64'h0);

        for (int i = 1; i < N; i++) do_write(i, 16'h7777);
        do_key(K1);
        ip_reset = 1'b1; cycle(); ip_reset = 1'b0;
        chk("midarm reset data", 64'(Data_out), 64'h0);
        chk("midarm reset lock", 64'(lock_status), 64'h0);
        for (int i = 0; i < N; i++) do_write(i, 16'h4444);
        do_key(K2);
        chk("KEY2 alone", 64'(lock_status), 64'hF);
        chk("KEY2 alone pulse", 64'(unlock_done), 64'h0);

        for (int c = 0; c < 3000; c++) begin
            ip_reset  = ($urandom_range(0, 299) == 0);
            write     = ($urandom_range(0, 2) == 0);
            addr      = AW'($urandom);
            wdata     = W'($urandom);
            key_valid = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            key = (r < 4) ? K1 : (r < 8) ? K2 : W'($urandom);
            cycle();
        end
        ip_reset = 1'b0; idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
